pic_ctrl_seq: RTL and testbench

// Synchronous, parametrised successor to the PIC control logic. Decodes the ICW1-4 init sequence and OCW1-3 writes,

---
 rtl/pic_ctrl_seq.sv | 338 +++++++++++++++++++++++++++++++++
 tb/tb_pic_ctrl_seq.sv | 288 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pic_ctrl_seq.sv
// -----------------------------------------------------------------------------
// pic_ctrl_seq
// Control half of a programmable interrupt controller. It decodes the ICW1-4
// initialisation sequence and the OCW1-3 operational writes, holds the
// mask/mode state, and runs the two-pulse INT/INTA acknowledge handshake that
// puts the interrupt vector on the bus. The IRR/ISR/priority resolver lives
// outside this block; it feeds irr_any/irr_id in and receives isr_set/ack_id
// and the EOI commands back.
//
// Ports
//   clk, rst_n            clock, asynchronous active-low reset
//   wr, A0, datain        host write strobe, register select, write data
//   INTA                  active-low acknowledge (already synchronised)
//   irr_any, irr_id       resolver: unmasked request present / its id
//   INT                   interrupt request to the CPU
//   impulse1, impulse2    first / second acknowledge pulse in progress
//   isr_set, ack_id       set-ISR pulse and the id being acknowledged
//   spurious              current acknowledge found no request
//   vector_oe, vector_out vector bus enable and value {base, ack_id}
//   end_ack               end of the second acknowledge pulse
//   eoi_pulse/cmd/level   OCW2 command or auto-EOI towards the ISR logic
//   maskreg               OCW1 interrupt mask
//   aeoi, rot_aeoi        auto-EOI mode, rotate-on-auto-EOI
//   RR_RIS, smm           OCW3 read select, special mask mode
//   icw3_reg              cascade configuration word (stored only)
//   ready                 initialisation sequence complete
// -----------------------------------------------------------------------------
module pic_ctrl_seq #(
  parameter int         NUM_IRQ   = 8,
  parameter int         IDW       = 3,
  parameter logic [7:0] MASK_INIT = 8'h00
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               wr,
  input  logic               A0,
  input  logic [7:0]         datain,
  input  logic               INTA,
  input  logic               irr_any,
  input  logic [IDW-1:0]     irr_id,
  output logic               INT,
  output logic               impulse1,
  output logic               impulse2,
  output logic               isr_set,
  output logic [IDW-1:0]     ack_id,
  output logic               spurious,
  output logic               vector_oe,
  output logic [7:0]         vector_out,
  output logic               end_ack,
  output logic               eoi_pulse,
  output logic [2:0]         eoi_cmd,
  output logic [IDW-1:0]     eoi_level,
  output logic [NUM_IRQ-1:0] maskreg,
  output logic               aeoi,
  output logic               rot_aeoi,
  output logic [1:0]         RR_RIS,
  output logic               smm,
  output logic [7:0]         icw3_reg,
  output logic               ready
);

  // Init FSM encoding
  localparam logic [2:0] ST_UNINIT = 3'd0;
  localparam logic [2:0] ST_ICW2   = 3'd1;
  localparam logic [2:0] ST_ICW3   = 3'd2;
  localparam logic [2:0] ST_ICW4   = 3'd3;
  localparam logic [2:0] ST_READY  = 3'd4;

  // Acknowledge FSM encoding
  localparam logic [1:0] AK_IDLE = 2'd0;
  localparam logic [1:0] AK_REQ  = 2'd1;
  localparam logic [1:0] AK_ACK1 = 2'd2;
  localparam logic [1:0] AK_ACK2 = 2'd3;

  // Id reported when the first INTA pulse finds no request
  localparam logic [IDW-1:0] LAST_ID = IDW'(NUM_IRQ - 1);

  // Configuration state
  logic [2:0]         r_init_st;
  logic               r_sngl;
  logic               r_ic4;
  logic [7-IDW:0]     r_base;
  logic [7:0]         r_icw3;
  logic [NUM_IRQ-1:0] r_mask;
  logic               r_aeoi;
  logic               r_rot_aeoi;
  logic               r_smm;
  logic [1:0]         r_rr_ris;

  // Handshake state
  logic [1:0]         r_ack_st;
  logic               r_inta_d;
  logic               r_int;
  logic               r_imp1;
  logic               r_imp2;
  logic               r_isr_set;
  logic [IDW-1:0]     r_ack_id;
  logic               r_spur;
  logic               r_voe;
  logic               r_end_ack;

  // EOI reporting, with one-deep holding slot for a deferred auto-EOI
  logic               r_eoi_pulse;
  logic [2:0]         r_eoi_cmd;
  logic [IDW-1:0]     r_eoi_level;
  logic               r_pend;
  logic [2:0]         r_pend_cmd;
  logic [IDW-1:0]     r_pend_level;

  // Write decode
  logic w_in_ready;
  logic w_in_icw;
  logic w_icw1;
  logic w_icw_pend;
  logic w_ocw1;
  logic w_ocw2;
  logic w_ocw3;
  logic w_inta_fall;
  logic w_inta_rise;
  logic [2:0] w_auto_cmd;

  assign w_in_ready  = (r_init_st == ST_READY);
  assign w_in_icw    = (r_init_st == ST_ICW2) || (r_init_st == ST_ICW3) ||
                       (r_init_st == ST_ICW4);
  assign w_icw1      = wr && !A0 && datain[4];
  assign w_icw_pend  = wr && A0 && w_in_icw;
  assign w_ocw1      = wr && A0 && w_in_ready;
  assign w_ocw2      = wr && !A0 && !datain[4] && !datain[3] && w_in_ready;
  assign w_ocw3      = wr && !A0 && !datain[4] &&  datain[3] && w_in_ready;
  assign w_inta_fall = r_inta_d && !INTA;
  assign w_inta_rise = !r_inta_d && INTA;
  assign w_auto_cmd  = r_rot_aeoi ? 3'b101 : 3'b001;

  // Init sequence and mode registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_init_st  <= ST_UNINIT;
      r_sngl     <= 1'b0;
      r_ic4      <= 1'b0;
      r_base     <= '0;
      r_icw3     <= '0;
      r_mask     <= MASK_INIT[NUM_IRQ-1:0];
      r_aeoi     <= 1'b0;
      r_rot_aeoi <= 1'b0;
      r_smm      <= 1'b0;
      r_rr_ris   <= 2'b00;
    end else if (w_icw1) begin
      // ICW1 restarts initialisation from any state
      r_init_st  <= ST_ICW2;
      r_sngl     <= datain[1];
      r_ic4      <= datain[0];
      r_mask     <= MASK_INIT[NUM_IRQ-1:0];
      r_aeoi     <= 1'b0;
      r_rot_aeoi <= 1'b0;
      r_smm      <= 1'b0;
      r_rr_ris   <= 2'b00;
    end else if (w_icw_pend) begin
      case (r_init_st)
        ST_ICW2: begin
          r_base <= datain[7:IDW];
          if (!r_sngl)    r_init_st <= ST_ICW3;
          else if (r_ic4) r_init_st <= ST_ICW4;
          else            r_init_st <= ST_READY;
        end
        ST_ICW3: begin
          r_icw3    <= datain;
          r_init_st <= r_ic4 ? ST_ICW4 : ST_READY;
        end
        ST_ICW4: begin
          r_aeoi    <= datain[1];
          r_init_st <= ST_READY;
        end
        default: ;
      endcase
    end else if (w_ocw1) begin
      r_mask <= datain[NUM_IRQ-1:0];
    end else if (w_ocw2) begin
      // Only the rotate-in-AEOI set/clear commands touch local state
      if (datain[7:5] == 3'b100)      r_rot_aeoi <= 1'b1;
      else if (datain[7:5] == 3'b000) r_rot_aeoi <= 1'b0;
    end else if (w_ocw3) begin
      if (datain[1]) r_rr_ris <= datain[1:0];
      if (datain[6]) r_smm    <= datain[5];
    end
  end

  // Acknowledge handshake: next-state decode
  logic [1:0]     w_ack_nxt;
  logic           w_int_nxt;
  logic           w_imp1_nxt;
  logic           w_imp2_nxt;
  logic           w_isr_nxt;
  logic [IDW-1:0] w_ack_id_nxt;
  logic           w_spur_nxt;
  logic           w_end_nxt;
  logic           w_auto_req;

  always_comb begin
    w_ack_nxt    = r_ack_st;
    w_int_nxt    = r_int;
    w_imp1_nxt   = r_imp1;
    w_imp2_nxt   = r_imp2;
    w_isr_nxt    = 1'b0;
    w_ack_id_nxt = r_ack_id;
    w_spur_nxt   = r_spur;
    w_end_nxt    = 1'b0;
    w_auto_req   = 1'b0;
    if (w_icw1) begin
      // Reinitialisation abandons any acknowledge in flight
      w_ack_nxt  = AK_IDLE;
      w_int_nxt  = 1'b0;
      w_imp1_nxt = 1'b0;
      w_imp2_nxt = 1'b0;
      w_spur_nxt = 1'b0;
    end else begin
      case (r_ack_st)
        AK_IDLE: begin
          if (w_in_ready && irr_any) begin
            w_ack_nxt = AK_REQ;
            w_int_nxt = 1'b1;
          end
        end
        AK_REQ: begin
          // INT is held even if the request goes away; the first INTA
          // pulse then resolves to the spurious id
          if (w_inta_fall) begin
            w_ack_nxt    = AK_ACK1;
            w_int_nxt    = 1'b0;
            w_imp1_nxt   = 1'b1;
            w_isr_nxt    = irr_any;
            w_spur_nxt   = !irr_any;
            w_ack_id_nxt = irr_any ? irr_id : LAST_ID;
          end
        end
        AK_ACK1: begin
          if (w_inta_fall) begin
            w_ack_nxt  = AK_ACK2;
            w_imp1_nxt = 1'b0;
            w_imp2_nxt = 1'b1;
          end
        end
        default: begin
          if (w_inta_rise) begin
            w_ack_nxt  = AK_IDLE;
            w_imp2_nxt = 1'b0;
            w_spur_nxt = 1'b0;
            w_end_nxt  = 1'b1;
            w_auto_req = r_aeoi && !r_spur;
          end
        end
      endcase
    end
  end

  // Acknowledge handshake: registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ack_st  <= AK_IDLE;
      r_inta_d  <= 1'b1;
      r_int     <= 1'b0;
      r_imp1    <= 1'b0;
      r_imp2    <= 1'b0;
      r_isr_set <= 1'b0;
      r_ack_id  <= '0;
      r_spur    <= 1'b0;
      r_voe     <= 1'b0;
      r_end_ack <= 1'b0;
    end else begin
      r_ack_st  <= w_ack_nxt;
      r_inta_d  <= INTA;
      r_int     <= w_int_nxt;
      r_imp1    <= w_imp1_nxt;
      r_imp2    <= w_imp2_nxt;
      r_isr_set <= w_isr_nxt;
      r_ack_id  <= w_ack_id_nxt;
      r_spur    <= w_spur_nxt;
      r_voe     <= w_imp2_nxt && !INTA;
      r_end_ack <= w_end_nxt;
    end
  end

  // EOI reporting: an OCW2 write wins the slot; a colliding auto-EOI is
  // parked and sent on the next free cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_eoi_pulse  <= 1'b0;
      r_eoi_cmd    <= 3'b000;
      r_eoi_level  <= '0;
      r_pend       <= 1'b0;
      r_pend_cmd   <= 3'b000;
      r_pend_level <= '0;
    end else begin
      r_eoi_pulse <= 1'b0;
      if (w_icw1) begin
        r_pend <= 1'b0;
      end else if (w_ocw2) begin
        r_eoi_pulse <= 1'b1;
        r_eoi_cmd   <= datain[7:5];
        r_eoi_level <= datain[IDW-1:0];
        if (w_auto_req) begin
          r_pend       <= 1'b1;
          r_pend_cmd   <= w_auto_cmd;
          r_pend_level <= r_ack_id;
        end
      end else if (w_auto_req) begin
        r_eoi_pulse <= 1'b1;
        r_eoi_cmd   <= w_auto_cmd;
        r_eoi_level <= r_ack_id;
      end else if (r_pend) begin
        r_eoi_pulse <= 1'b1;
        r_eoi_cmd   <= r_pend_cmd;
        r_eoi_level <= r_pend_level;
        r_pend      <= 1'b0;
      end
    end
  end

  assign INT        = r_int;
  assign impulse1   = r_imp1;
  assign impulse2   = r_imp2;
  assign isr_set    = r_isr_set;
  assign ack_id     = r_ack_id;
  assign spurious   = r_spur;
  assign vector_oe  = r_voe;
  assign vector_out = {r_base, r_ack_id};
  assign end_ack    = r_end_ack;
  assign eoi_pulse  = r_eoi_pulse;
  assign eoi_cmd    = r_eoi_cmd;
  assign eoi_level  = r_eoi_level;
  assign maskreg    = r_mask;
  assign aeoi       = r_aeoi;
  assign rot_aeoi   = r_rot_aeoi;
  assign RR_RIS     = r_rr_ris;
  assign smm        = r_smm;
  assign icw3_reg   = r_icw3;
  assign ready      = (r_init_st == ST_READY);

endmodule

// File: tb/tb_pic_ctrl_seq.sv
module tb_pic_ctrl_seq;
  localparam int         NUM_IRQ   = 8;
  localparam int         IDW       = 3;
  localparam logic [7:0] MASK_INIT = 8'h00;

  logic clk, rst_n, wr, A0, INTA, irr_any;
  logic [7:0] datain;
  logic [IDW-1:0] irr_id;
  logic INT, impulse1, impulse2, isr_set, spurious, vector_oe, end_ack, eoi_pulse;
  logic aeoi, rot_aeoi, smm, ready;
  logic [IDW-1:0] ack_id, eoi_level;
  logic [7:0] vector_out, icw3_reg;
  logic [2:0] eoi_cmd;
  logic [NUM_IRQ-1:0] maskreg;
  logic [1:0] RR_RIS;

  pic_ctrl_seq #(.NUM_IRQ(NUM_IRQ), .IDW(IDW), .MASK_INIT(MASK_INIT)) dut (
    .clk(clk), .rst_n(rst_n), .wr(wr), .A0(A0), .datain(datain), .INTA(INTA),
    .irr_any(irr_any), .irr_id(irr_id), .INT(INT), .impulse1(impulse1),
    .impulse2(impulse2), .isr_set(isr_set), .ack_id(ack_id), .spurious(spurious),
    .vector_oe(vector_oe), .vector_out(vector_out), .end_ack(end_ack),
    .eoi_pulse(eoi_pulse), .eoi_cmd(eoi_cmd), .eoi_level(eoi_level),
    .maskreg(maskreg), .aeoi(aeoi), .rot_aeoi(rot_aeoi), .RR_RIS(RR_RIS),
    .smm(smm), .icw3_reg(icw3_reg), .ready(ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  // Reference model: programmer-visible state as the host would track it
  logic [7:0] m_mask, m_base, m_icw3;
  logic       m_aeoi, m_rot, m_smm, m_ready;
  logic [1:0] m_rr;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr_cycle(input logic a, input logic [7:0] d);
    wr = 1'b1; A0 = a; datain = d;
    tick();
    wr = 1'b0; A0 = 1'b0; datain = 8'h00;
  endtask

  task automatic check_cfg(input string tag);
    chk({tag, "_mask"},  maskreg,  m_mask);
    chk({tag, "_aeoi"},  aeoi,     m_aeoi);
    chk({tag, "_rot"},   rot_aeoi, m_rot);
    chk({tag, "_smm"},   smm,      m_smm);
    chk({tag, "_rr"},    RR_RIS,   m_rr);
    chk({tag, "_icw3"},  icw3_reg, m_icw3);
    chk({tag, "_ready"}, ready,    m_ready);
  endtask

  task automatic do_init(input logic [7:0] w1, input logic [7:0] w2,
                         input logic [7:0] w3, input logic [7:0] w4);
    wr_cycle(1'b0, w1);
    m_mask = MASK_INIT; m_aeoi = 1'b0; m_rot = 1'b0; m_smm = 1'b0;
    m_rr = 2'b00; m_ready = 1'b0;
    chk("icw1_ready", ready, 1'b0);
    chk("icw1_mask", maskreg, m_mask);
    chk("icw1_int", INT, 1'b0);
    chk("icw1_imp", {impulse1, impulse2, vector_oe, spurious}, 4'b0000);
    wr_cycle(1'b1, w2);
    m_base = w2 & 8'hF8;
    chk("icw2_ready", ready, w1[1] && !w1[0]);
    if (!w1[1]) begin
      wr_cycle(1'b1, w3);
      m_icw3 = w3;
    end
    if (w1[0]) begin
      wr_cycle(1'b1, w4);
      m_aeoi = w4[1];
    end
    m_ready = 1'b1;
    check_cfg("init");
  endtask

  task automatic do_ocw1(input logic [7:0] d);
    wr_cycle(1'b1, d);
    m_mask = d;
    chk("ocw1_mask", maskreg, m_mask);
  endtask

  task automatic do_ocw2(input logic [7:0] d);
    wr_cycle(1'b0, d);
    if (d[7:5] == 3'b100) m_rot = 1'b1;
    if (d[7:5] == 3'b000) m_rot = 1'b0;
    chk("ocw2_pulse", eoi_pulse, 1'b1);
    chk("ocw2_cmd", eoi_cmd, d[7:5]);
    chk("ocw2_level", eoi_level, d[2:0]);
    chk("ocw2_rot", rot_aeoi, m_rot);
    tick();
    chk("ocw2_pulse_end", eoi_pulse, 1'b0);
  endtask

  task automatic do_ocw3(input logic [7:0] d);
    wr_cycle(1'b0, d);
    if (d[1]) m_rr = d[1:0];
    if (d[6]) m_smm = d[5];
    chk("ocw3_rr", RR_RIS, m_rr);
    chk("ocw3_smm", smm, m_smm);
  endtask

  // Full acknowledge: request, two INTA pulses, optional OCW2 colliding with
  // the closing INTA rise.
  task automatic do_ack(input logic any, input logic [2:0] id, input logic collide);
    logic [2:0] eid;
    logic       exp_auto;
    eid      = any ? id : 3'(NUM_IRQ - 1);
    exp_auto = m_aeoi && any;
    irr_any = 1'b1; irr_id = id;
    tick();
    chk("ack_int_on", INT, 1'b1);
    irr_any = any;
    tick();
    chk("ack_int_hold", INT, 1'b1);
    chk("ack_imp1_pre", impulse1, 1'b0);
    INTA = 1'b0;
    tick();
    chk("ack1_int", INT, 1'b0);
    chk("ack1_imp1", impulse1, 1'b1);
    chk("ack1_isr_set", isr_set, any);
    chk("ack1_id", ack_id, eid);
    chk("ack1_spur", spurious, !any);
    chk("ack1_voe", vector_oe, 1'b0);
    irr_any = 1'b0; INTA = 1'b1;
    tick();
    chk("ack1_isr_once", isr_set, 1'b0);
    chk("ack1_imp", {impulse1, impulse2}, 2'b10);
    INTA = 1'b0;
    tick();
    chk("ack2_imp", {impulse1, impulse2}, 2'b01);
    chk("ack2_voe", vector_oe, 1'b1);
    chk("ack2_vec", vector_out, {m_base[7:3], eid});
    tick();
    chk("ack2_voe_hold", vector_oe, 1'b1);
    INTA = 1'b1;
    if (collide) begin
      wr = 1'b1; A0 = 1'b0; datain = 8'h62;
    end
    tick();
    wr = 1'b0; datain = 8'h00;
    chk("end_ack", end_ack, 1'b1);
    chk("end_imp2", impulse2, 1'b0);
    chk("end_voe", vector_oe, 1'b0);
    chk("end_spur", spurious, 1'b0);
    if (collide) begin
      chk("coll_ocw2_pulse", eoi_pulse, 1'b1);
      chk("coll_ocw2_cmd", eoi_cmd, 3'b011);
      chk("coll_ocw2_level", eoi_level, 3'd2);
      tick();
      chk("coll_end_ack_off", end_ack, 1'b0);
      chk("coll_auto_pulse", eoi_pulse, exp_auto);
      if (exp_auto) begin
        chk("coll_auto_cmd", eoi_cmd, m_rot ? 3'b101 : 3'b001);
        chk("coll_auto_level", eoi_level, eid);
      end
    end else begin
      chk("auto_pulse", eoi_pulse, exp_auto);
      if (exp_auto) begin
        chk("auto_cmd", eoi_cmd, m_rot ? 3'b101 : 3'b001);
        chk("auto_level", eoi_level, eid);
      end
    end
    tick();
    chk("post_eoi", eoi_pulse, 1'b0);
    chk("post_end_ack", end_ack, 1'b0);
    chk("post_int", INT, 1'b0);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; wr = 1'b0; A0 = 1'b0; datain = 8'h00;
    INTA = 1'b1; irr_any = 1'b0; irr_id = '0;
    m_mask = MASK_INIT; m_base = 8'h00; m_icw3 = 8'h00; m_aeoi = 1'b0;
    m_rot = 1'b0; m_smm = 1'b0; m_ready = 1'b0; m_rr = 2'b00;
    tick(); tick();

    // Reset values
    chk("rst_hs", {INT, impulse1, impulse2, isr_set, spurious, vector_oe, end_ack, eoi_pulse}, 8'h00);
    chk("rst_ids", {ack_id, eoi_level, eoi_cmd}, 9'h000);
    chk("rst_vec", vector_out, 8'h00);
    check_cfg("rst");
    rst_n = 1'b1;
    tick();

    // Not initialised: requests are ignored
    irr_any = 1'b1; tick(); tick();
    chk("uninit_int", INT, 1'b0);
    irr_any = 1'b0;

    // T1: single, with ICW4 (AEOI)
    do_init(8'h13, 8'h40, 8'h00, 8'h03);
    chk("t1_aeoi", aeoi, 1'b1);

    // INTA in IDLE is ignored
    INTA = 1'b0; tick(); tick();
    chk("idle_inta_imp1", impulse1, 1'b0);
    INTA = 1'b1; tick();

    // T2: normal acknowledge with auto-EOI
    do_ack(1'b1, 3'd5, 1'b0);
    // Rotate in AEOI, then cleared
    do_ocw2(8'h80);
    do_ack(1'b1, 3'd2, 1'b0);
    do_ocw2(8'h00);
    // OCW2 colliding with the auto-EOI
    do_ack(1'b1, 3'd6, 1'b1);

    // T3: cascade word, no ICW4
    do_init(8'h10, 8'h40, 8'hA5, 8'h00);
    chk("t3_icw3", icw3_reg, 8'hA5);
    do_ack(1'b1, 3'd3, 1'b0);

    // T4: spurious acknowledge
    do_ack(1'b0, 3'd4, 1'b0);

    // T5: operational commands
    do_ocw1(8'hF0);
    do_ocw2(8'h63);
    do_ocw3(8'h0B);

    // T6a: ICW1 during ACK1 aborts the handshake
    irr_any = 1'b1; irr_id = 3'd1;
    tick();
    INTA = 1'b0;
    tick();
    chk("t6_in_ack1", impulse1, 1'b1);
    irr_any = 1'b0; INTA = 1'b1;
    do_init(8'h13, 8'h48, 8'h00, 8'h03);
    do_ack(1'b1, 3'd1, 1'b0);

    // T6b: reset mid-ACK2 acts immediately
    do_ocw1(8'h5A);
    irr_any = 1'b1; irr_id = 3'd6;
    tick();
    INTA = 1'b0; tick();
    irr_any = 1'b0; INTA = 1'b1; tick();
    INTA = 1'b0; tick();
    chk("t6_in_ack2", impulse2, 1'b1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("t6_rst_hs", {INT, impulse1, impulse2, vector_oe}, 4'b0000);
    chk("t6_rst_ready", ready, 1'b0);
    chk("t6_rst_mask", maskreg, MASK_INIT);
    chk("t6_rst_vec", vector_out, 8'h00);
    INTA = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    m_base = 8'h00; m_icw3 = 8'h00;
    do_init(8'h11, 8'h20, 8'h3C, 8'h02);

    // Randomised traffic against the model
    for (int i = 0; i < 60; i++) begin
      case ($urandom_range(0, 6))
        0: do_ocw1(8'($urandom));
        1: do_ocw2(8'($urandom) & 8'hE7);
        2: do_ocw3((8'($urandom) & 8'hE7) | 8'h08);
        3, 4, 5: do_ack($urandom_range(0, 3) != 0, 3'($urandom), 1'($urandom));
        default: do_init((8'($urandom) & 8'hEF) | 8'h10, 8'($urandom),
                         8'($urandom), 8'($urandom));
      endcase
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
